// File: rtl/coin_acceptor.sv
// Coin-slot front end: debounces the slot sensor, classifies coins into credit units,
// buffers them in a small FIFO and hands them to the vending FSM while it accepts credit.
//   state | meaning
//   IDLE  | slot empty, waiting for a rising sensor
//   QUAL  | sensor high, counting stable cycles before trusting it
//   HELD  | coin qualified and type latched, waiting for it to leave the slot
//   JAM   | coin stuck too long, waiting for a clean release before returning it
module coin_acceptor #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_sense,
  input  logic [1:0]                    coin_type,
  input  logic                          accept_en,
  output logic [3:0]                    coin_in,
  output logic                          reject_out,
  output logic                          jam_out,
  output logic [$clog2(FIFO_DEPTH):0]   pending_out
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, QUAL, HELD, JAM} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   qual_q, qual_d;
  logic [DW-1:0]   low_q, low_d;
  logic [SW-1:0]   stuck_q, stuck_d;
  logic [1:0]      type_q, type_d;
  logic            reject_q, reject_d;

  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            low_done;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [2:0]      push_val;

  // Timers count down to 1; reaching 1 on a qualifying cycle is the terminal count.
  assign low_done = !coin_sense && (low_q == DW'(1));
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop      = accept_en && !empty;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      qual_q   <= '0;
      low_q    <= '0;
      stuck_q  <= '0;
      type_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qual_q   <= qual_d;
      low_q    <= low_d;
      stuck_q  <= stuck_d;
      type_q   <= type_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    low_d   = low_q;
    stuck_d = stuck_q;
    type_d  = type_q;
    case (state_q)
      IDLE: begin
        if (coin_sense) begin
          state_d = QUAL;
          qual_d  = DW'(DEB_CYCLES - 1);
        end
      end
      QUAL: begin
        if (!coin_sense) begin
          state_d = IDLE;
        end else if (qual_q == DW'(1)) begin
          state_d = HELD;
          type_d  = coin_type;
          stuck_d = SW'(STUCK_CYCLES);
          low_d   = DW'(DEB_CYCLES);
        end else begin
          qual_d = qual_q - DW'(1);
        end
      end
      HELD: begin
        low_d   = coin_sense ? DW'(DEB_CYCLES) : low_q - DW'(1);
        stuck_d = stuck_q - DW'(0) - SW'(1);
        // A coin that clears the slot on the same cycle the stuck timer expires still counts as passed.
        if (low_done) begin
          state_d = IDLE;
        end else if (stuck_q == SW'(1)) begin
          state_d = JAM;
        end
      end
      JAM: begin
        low_d = coin_sense ? DW'(DEB_CYCLES) : low_q - DW'(1);
        if (low_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    jam_out  = (state_q == JAM);
    push_req = (state_q == HELD) && low_done && (type_q != 2'b11);
    reject_d = ((state_q == HELD) && low_done && ((type_q == 2'b11) || (full && !pop)))
             || ((state_q == JAM) && low_done);
    case (type_q)
      2'b00:   push_val = 3'd1;
      2'b01:   push_val = 3'd2;
      2'b10:   push_val = 3'd5;
      default: push_val = 3'd0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_val;
  end

  assign coin_in     = pop ? {1'b0, mem_q[rd_q]} : 4'd0;
  assign reject_out  = reject_q;
  assign pending_out = cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: debounce, buffering, rejects, jam and reset recovery.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_sense = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       accept_en = 1'b0;
  logic [3:0] coin_in;
  logic       reject_out;
  logic       jam_out;
  logic [2:0] pending_out;

  int checks = 0;
  int errors = 0;

  int coin_log[$];
  int rej_cnt = 0;
  int viol_cnt = 0;

  int base_coin;
  int base_rej;

  coin_acceptor #(.DEB_CYCLES(4), .STUCK_CYCLES(64), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .coin_sense(coin_sense),
    .coin_type(coin_type),
    .accept_en(accept_en),
    .coin_in(coin_in),
    .reject_out(reject_out),
    .jam_out(jam_out),
    .pending_out(pending_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coin_in !== 4'd0) coin_log.push_back(int'(coin_in));
    if (reject_out === 1'b1) rej_cnt++;
    if (accept_en === 1'b0 && coin_in !== 4'd0) viol_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic insert(input logic [1:0] t, input int hi, input int lo);
    coin_type  = t;
    coin_sense = 1'b1;
    tick(hi);
    coin_sense = 1'b0;
    tick(lo);
  endtask

  task automatic mark();
    base_coin = coin_log.size();
    base_rej  = rej_cnt;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_pending", pending_out, 0);
    check("rst_coin", coin_in, 0);
    check("rst_reject", reject_out, 0);
    check("rst_jam", jam_out, 0);
    rst = 1'b1;
    tick(2);

    // Clean 50c coin with credit enabled
    mark();
    accept_en  = 1'b1;
    coin_type  = 2'b10;
    coin_sense = 1'b1;
    tick(10);
    coin_sense = 1'b0;
    tick(3);
    check("c50_early", coin_in, 0);
    tick(1);
    check("c50_value", coin_in, 5);
    check("c50_pend1", pending_out, 1);
    tick(1);
    check("c50_after", coin_in, 0);
    check("c50_pend0", pending_out, 0);
    tick(4);
    check("c50_count", coin_log.size() - base_coin, 1);
    check("c50_norej", rej_cnt - base_rej, 0);

    // Short bounces never qualify
    mark();
    insert(2'b00, 1, 3);
    insert(2'b01, 2, 3);
    insert(2'b10, 3, 3);
    tick(4);
    check("bnc_coins", coin_log.size() - base_coin, 0);
    check("bnc_rej", rej_cnt - base_rej, 0);
    check("bnc_pend", pending_out, 0);

    // 20c coin bouncing twice on its falling edge
    mark();
    coin_type  = 2'b01;
    coin_sense = 1'b1;
    tick(8);
    coin_sense = 1'b0; tick(2);
    coin_sense = 1'b1; tick(1);
    coin_sense = 1'b0; tick(2);
    coin_sense = 1'b1; tick(1);
    coin_sense = 1'b0; tick(8);
    check("b20_count", coin_log.size() - base_coin, 1);
    if (coin_log.size() > base_coin) check("b20_value", coin_log[base_coin], 2);
    check("b20_rej", rej_cnt - base_rej, 0);

    // Buffering with credit disabled, then overflow reject
    mark();
    accept_en = 1'b0;
    insert(2'b00, 6, 6);
    insert(2'b01, 6, 6);
    insert(2'b10, 6, 6);
    insert(2'b00, 6, 6);
    check("buf_pend4", pending_out, 4);
    check("buf_nocoin", coin_log.size() - base_coin, 0);
    coin_type  = 2'b00;
    coin_sense = 1'b1;
    tick(6);
    coin_sense = 1'b0;
    tick(3);
    check("ovf_rej_pre", reject_out, 0);
    tick(1);
    check("ovf_rej", reject_out, 1);
    tick(1);
    check("ovf_rej_post", reject_out, 0);
    check("ovf_pend", pending_out, 4);
    tick(2);
    check("ovf_rejcnt", rej_cnt - base_rej, 1);

    // Drain in arrival order, one coin per accept cycle
    accept_en = 1'b1;
    #1;
    check("drain0", coin_in, 1);
    tick(1);
    check("drain1", coin_in, 2);
    tick(1);
    check("drain2", coin_in, 5);
    tick(1);
    check("drain3", coin_in, 1);
    tick(1);
    check("drain_end", coin_in, 0);
    check("drain_pend", pending_out, 0);

    // Invalid coin is returned and buffer unchanged
    accept_en = 1'b0;
    insert(2'b01, 6, 6);
    check("inv_pend_pre", pending_out, 1);
    mark();
    insert(2'b11, 6, 6);
    check("inv_rej", rej_cnt - base_rej, 1);
    check("inv_pend", pending_out, 1);
    accept_en = 1'b1;
    #1;
    check("inv_drain", coin_in, 2);
    tick(1);
    check("inv_drain_pend", pending_out, 0);

    // Jam: sensor stuck high
    mark();
    coin_type  = 2'b00;
    coin_sense = 1'b1;
    tick(67);
    check("jam_pre", jam_out, 0);
    tick(1);
    check("jam_set", jam_out, 1);
    tick(32);
    check("jam_hold", jam_out, 1);
    coin_sense = 1'b0;
    tick(3);
    check("jam_rel_pre", jam_out, 1);
    check("jam_rej_pre", reject_out, 0);
    tick(1);
    check("jam_clear", jam_out, 0);
    check("jam_rej", reject_out, 1);
    tick(3);
    check("jam_rejcnt", rej_cnt - base_rej, 1);
    check("jam_nocredit", coin_log.size() - base_coin, 0);

    // Asynchronous reset mid-coin with two coins pending
    accept_en = 1'b0;
    insert(2'b00, 6, 6);
    insert(2'b01, 6, 6);
    check("rm_pend2", pending_out, 2);
    coin_type  = 2'b10;
    coin_sense = 1'b1;
    tick(6);
    #2;
    rst = 1'b0;
    accept_en = 1'b1;
    #1;
    check("rm_pend0", pending_out, 0);
    check("rm_coin0", coin_in, 0);
    check("rm_jam0", jam_out, 0);
    check("rm_rej0", reject_out, 0);
    tick(2);
    coin_sense = 1'b0;
    rst = 1'b1;
    tick(3);
    mark();
    insert(2'b00, 6, 8);
    check("rm_fresh_cnt", coin_log.size() - base_coin, 1);
    if (coin_log.size() > base_coin) check("rm_fresh_val", coin_log[base_coin], 1);
    check("rm_fresh_rej", rej_cnt - base_rej, 0);
    check("rm_pend_end", pending_out, 0);

    check("no_credit_when_disabled", viol_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
